fault_supervisor: RTL and testbench
===================================

FAULT_SUPERVISOR -- requirements
Module: fault_supervisor

Interface
REQ-001 SHALL have parameter clkFreqIn_MHz, default 40, clock frequency in MHz.
REQ-002 SHALL have parameter RestartDelay_us, default 100, post-clear hold-off in microseconds.
REQ-003 SHALL have parameter ChMask, default 4'hF, 4-bit mask; a 0 bit disables that watchdog channel.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port TimeOutIn  input  4  level timeout flags from four upstream signal-change watchdogs.
REQ-007 SHALL have port RunReq  input  1  level request to enable modulation.
REQ-008 SHALL have port FaultClr  input  1  single-cycle fault-clear request.
REQ-009 SHALL have port PwmEn  output  1  registered modulation enable.
REQ-010 SHALL have port FaultLatched  output  4  sticky per-channel fault flags.
REQ-011 SHALL have port FirstFault  output  2  index of the first channel to fault.
REQ-012 SHALL have port ClrRej  output  1  one-cycle pulse when FaultClr is refused.
REQ-013 SHALL have port State  output  2  current state encoding.

Function
REQ-014 SHALL define the effective fault vector F = TimeOutIn AND ChMask, sampled on each rising edge.
REQ-015 SHALL implement four states: IDLE=0, RUN=1, FAULT=2, RECOVER=3.
REQ-016 SHALL, in IDLE, go to FAULT if F!=0; otherwise go to RUN if RunReq=1; otherwise stay in IDLE.
REQ-017 SHALL, in RUN, go to FAULT if F!=0 (fault has priority); otherwise go to IDLE if RunReq=0.
REQ-018 SHALL, in FAULT, go to RECOVER only if FaultClr=1 and F=0.
REQ-019 SHALL, in FAULT, pulse ClrRej for exactly one cycle if FaultClr=1 and F!=0, and stay in FAULT.
REQ-020 SHALL, in RECOVER, go to FAULT if F!=0; otherwise go to IDLE when the delay counter reaches PR-1, where PR = clkFreqIn_MHz*RestartDelay_us.
REQ-021 SHALL register PwmEn as 1 exactly when the next state is RUN, giving one-edge latency from sampled input to output.
REQ-022 SHALL guarantee that PwmEn is 0 on the same edge at which a nonzero F is first sampled.
REQ-023 SHALL update FaultLatched each edge as FaultLatched OR F.
REQ-024 SHALL clear FaultLatched only on an accepted clear (FAULT->RECOVER); a fault on that same edge is impossible, since acceptance requires F=0.
REQ-025 SHALL capture FirstFault on every transition into FAULT, choosing the lowest index when several F bits are set.
REQ-026 SHALL hold FirstFault otherwise, including across RECOVER and IDLE.
REQ-027 SHALL use a 24-bit delay counter, zeroed on entry to RECOVER and incremented each cycle while in RECOVER.
REQ-028 SHALL, if RunReq=1 is held through RECOVER, not enter RUN directly from RECOVER: it passes through IDLE, so PwmEn rises two edges after the counter reaches PR-1.
REQ-029 SHALL treat PR<=1 as an immediate RECOVER->IDLE on the first RECOVER cycle.
REQ-030 SHALL ignore FaultClr outside FAULT, with no ClrRej pulse.

Reset
REQ-031 SHALL, while rst=1 at a rising edge, force State=IDLE, PwmEn=0, FaultLatched=0, FirstFault=0, ClrRej=0 and the counter to 0.
REQ-032 SHALL take reset in any state, including mid-RECOVER, and abort the count.
REQ-033 SHALL evaluate inputs normally on the first edge after rst falls.

Structure
REQ-034 SHALL place the state encodings, channel count (4) and counter width (24) in a shared package, fault_supervisor_pkg.
REQ-035 SHALL implement the restart hold-off as one sub-module, supervisor_delay_cnt, with inputs clear and enable and output done.
REQ-036 SHALL keep the state register, latches and priority encoder in the top module.

Verification (bench: clkFreqIn_MHz=1, RestartDelay_us=10, so PR=10)
REQ-037 SHALL cover: RunReq=1 from IDLE with F=0 -> State=RUN and PwmEn=1 after 1 edge.
REQ-038 SHALL cover: in RUN, TimeOutIn=4'b0100 -> PwmEn=0, State=FAULT, FaultLatched=4'b0100, FirstFault=2 on the same edge.
REQ-039 SHALL cover: in FAULT, TimeOutIn=4'b0100 held, FaultClr pulse -> ClrRej=1 for 1 cycle, State stays FAULT; then TimeOutIn=0 plus FaultClr -> RECOVER, FaultLatched=0, IDLE after 10 cycles.
REQ-040 SHALL cover: in RUN, TimeOutIn=4'b1010 simultaneously -> FirstFault=1, FaultLatched=4'b1010.
REQ-041 SHALL cover: TimeOutIn=4'b0001 at RECOVER cycle 5 -> State=FAULT, and a later clear restarts the count from 0 (full 10 cycles).
REQ-042 SHALL cover: ChMask=4'b1110, TimeOutIn=4'b0001 in RUN -> PwmEn stays 1, FaultLatched=0; rst asserted mid-RECOVER -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/fault_supervisor_pkg.sv
// Shared definitions for the fault supervisor: state encodings, channel count,
// hold-off counter width and the counter terminal-value helper.
package fault_supervisor_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_FAULT   = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  // Terminal count of the hold-off; a period of 0 or 1 collapses to an immediate exit.
  function automatic logic [CNT_W-1:0] delay_limit(input int pr);
    if (pr > 1) begin
      return CNT_W'(pr - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/supervisor_delay_cnt.sv
// Restart hold-off counter: zeroed by clear, counts while enabled, and flags
// done once it sits at the terminal value.
module supervisor_delay_cnt
  import fault_supervisor_pkg::*;
#(
  parameter logic [CNT_W-1:0] LIMIT = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The count parks at LIMIT, so an equality test is enough for done.
  assign done = (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !done) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fault_supervisor.sv
// Modulation-enable supervisor: gates PwmEn on watchdog timeouts, latches which
// channels faulted, and enforces a timed hold-off after an accepted fault clear.
module fault_supervisor
  import fault_supervisor_pkg::*;
#(
  parameter int                clkFreqIn_MHz   = 40,
  parameter int                RestartDelay_us = 100,
  parameter logic [NUM_CH-1:0] ChMask          = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] TimeOutIn,
  input  logic              RunReq,
  input  logic              FaultClr,
  output logic              PwmEn,
  output logic [NUM_CH-1:0] FaultLatched,
  output logic [1:0]        FirstFault,
  output logic              ClrRej,
  output logic [1:0]        State
);

  localparam int               PR    = clkFreqIn_MHz * RestartDelay_us;
  localparam logic [CNT_W-1:0] LIMIT = delay_limit(PR);

  state_e            state_q, state_d;
  logic              pwm_en_q, pwm_en_d;
  logic [NUM_CH-1:0] latched_q, latched_d;
  logic [1:0]        first_q, first_d;
  logic              clr_rej_q, clr_rej_d;

  logic [NUM_CH-1:0] fault_vec;
  logic              any_fault;
  logic              clr_accept;
  logic              delay_done;

  assign fault_vec = TimeOutIn & ChMask;
  assign any_fault = |fault_vec;

  // Lowest set index wins when several channels time out together.
  function automatic logic [1:0] lowest_index(input logic [NUM_CH-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    state_d    = state_q;
    clr_rej_d  = 1'b0;
    clr_accept = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_fault) begin
          state_d = ST_FAULT;
        end else if (RunReq) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (any_fault) begin
          state_d = ST_FAULT;
        end else if (!RunReq) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (FaultClr) begin
          if (any_fault) begin
            clr_rej_d = 1'b1;
          end else begin
            state_d    = ST_RECOVER;
            clr_accept = 1'b1;
          end
        end
      end
      ST_RECOVER: begin
        if (any_fault) begin
          state_d = ST_FAULT;
        end else if (delay_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs follow the next state so a fresh fault drops PwmEn on the same edge.
  always_comb begin
    pwm_en_d  = (state_d == ST_RUN);
    latched_d = clr_accept ? '0 : (latched_q | fault_vec);
    first_d   = first_q;
    if ((state_d == ST_FAULT) && (state_q != ST_FAULT)) begin
      first_d = lowest_index(fault_vec);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pwm_en_q  <= 1'b0;
      latched_q <= '0;
      first_q   <= '0;
      clr_rej_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwm_en_q  <= pwm_en_d;
      latched_q <= latched_d;
      first_q   <= first_d;
      clr_rej_q <= clr_rej_d;
    end
  end

  supervisor_delay_cnt #(
    .LIMIT (LIMIT)
  ) u_delay_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (clr_accept),
    .enable (state_q == ST_RECOVER),
    .done   (delay_done)
  );

  assign PwmEn        = pwm_en_q;
  assign FaultLatched = latched_q;
  assign FirstFault   = first_q;
  assign ClrRej       = clr_rej_q;
  assign State        = state_q;

endmodule

// File: tb/tb_fault_supervisor.sv
// Scoreboard bench for fault_supervisor with a 10-cycle hold-off; a second
// instance with channel 0 masked off covers the channel-mask behaviour.
module tb_fault_supervisor;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FLT  = 2'd2;
  localparam logic [1:0] S_REC  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] time_out_in = 4'd0;
  logic       run_req = 1'b0;
  logic       fault_clr = 1'b0;

  logic       pwm_en, clr_rej;
  logic [3:0] fault_latched;
  logic [1:0] first_fault, state;
  logic       m_pwm_en, m_clr_rej;
  logic [3:0] m_fault_latched;
  logic [1:0] m_first_fault, m_state;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    bit         masked;
    logic [1:0] st;
    logic       pwm;
    logic [3:0] lat;
    logic [1:0] first;
    logic       rej;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  fault_supervisor #(
    .clkFreqIn_MHz   (1),
    .RestartDelay_us (10),
    .ChMask          (4'hF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .TimeOutIn    (time_out_in),
    .RunReq       (run_req),
    .FaultClr     (fault_clr),
    .PwmEn        (pwm_en),
    .FaultLatched (fault_latched),
    .FirstFault   (first_fault),
    .ClrRej       (clr_rej),
    .State        (state)
  );

  fault_supervisor #(
    .clkFreqIn_MHz   (1),
    .RestartDelay_us (10),
    .ChMask          (4'b1110)
  ) dut_m (
    .clk          (clk),
    .rst          (rst),
    .TimeOutIn    (time_out_in),
    .RunReq       (run_req),
    .FaultClr     (fault_clr),
    .PwmEn        (m_pwm_en),
    .FaultLatched (m_fault_latched),
    .FirstFault   (m_first_fault),
    .ClrRej       (m_clr_rej),
    .State        (m_state)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic popAndCompare();
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_underflow", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    if (!e.masked) begin
      checkOutput({e.tag, ".state"}, 32'(state), 32'(e.st));
      checkOutput({e.tag, ".pwm"}, 32'(pwm_en), 32'(e.pwm));
      checkOutput({e.tag, ".latched"}, 32'(fault_latched), 32'(e.lat));
      checkOutput({e.tag, ".first"}, 32'(first_fault), 32'(e.first));
      checkOutput({e.tag, ".clrrej"}, 32'(clr_rej), 32'(e.rej));
    end else begin
      checkOutput({e.tag, ".m_state"}, 32'(m_state), 32'(e.st));
      checkOutput({e.tag, ".m_pwm"}, 32'(m_pwm_en), 32'(e.pwm));
      checkOutput({e.tag, ".m_latched"}, 32'(m_fault_latched), 32'(e.lat));
      checkOutput({e.tag, ".m_first"}, 32'(m_first_fault), 32'(e.first));
      checkOutput({e.tag, ".m_clrrej"}, 32'(m_clr_rej), 32'(e.rej));
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check.
  task automatic applyStimulus(input string tag, input bit masked, input logic r,
                               input logic [3:0] to, input logic rr, input logic fc,
                               input logic [1:0] e_st, input logic e_pwm,
                               input logic [3:0] e_lat, input logic [1:0] e_first,
                               input logic e_rej);
    exp_t e;
    @(negedge clk);
    rst         = r;
    time_out_in = to;
    run_req     = rr;
    fault_clr   = fc;
    e.tag = tag; e.masked = masked; e.st = e_st; e.pwm = e_pwm;
    e.lat = e_lat; e.first = e_first; e.rej = e_rej;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    popAndCompare();
  endtask

  initial begin
    $display("[TB] start");

    applyStimulus("reset", 0, 1, 4'h0, 0, 0, S_IDLE, 0, 4'h0, 2'd0, 0);
    applyStimulus("idle_hold", 0, 0, 4'h0, 0, 0, S_IDLE, 0, 4'h0, 2'd0, 0);
    applyStimulus("run_start", 0, 0, 4'h0, 1, 0, S_RUN, 1, 4'h0, 2'd0, 0);
    applyStimulus("run_hold", 0, 0, 4'h0, 1, 0, S_RUN, 1, 4'h0, 2'd0, 0);
    applyStimulus("fault_ch2", 0, 0, 4'b0100, 1, 0, S_FLT, 0, 4'b0100, 2'd2, 0);
    applyStimulus("clr_rejected", 0, 0, 4'b0100, 1, 1, S_FLT, 0, 4'b0100, 2'd2, 1);
    applyStimulus("clrrej_one_cycle", 0, 0, 4'b0100, 1, 0, S_FLT, 0, 4'b0100, 2'd2, 0);
    applyStimulus("fault_sticky", 0, 0, 4'h0, 0, 0, S_FLT, 0, 4'b0100, 2'd2, 0);
    applyStimulus("clr_accept", 0, 0, 4'h0, 0, 1, S_REC, 0, 4'h0, 2'd2, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("holdoff_a%0d", i), 0, 0, 4'h0, 0, (i == 3),
                    (i < 9) ? S_REC : S_IDLE, 0, 4'h0, 2'd2, 0);
    end

    applyStimulus("run_again", 0, 0, 4'h0, 1, 0, S_RUN, 1, 4'h0, 2'd2, 0);
    applyStimulus("fault_multi", 0, 0, 4'b1010, 1, 0, S_FLT, 0, 4'b1010, 2'd1, 0);
    applyStimulus("clr_accept_b", 0, 0, 4'h0, 1, 1, S_REC, 0, 4'h0, 2'd1, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("holdoff_b%0d", i), 0, 0, 4'h0, 1, 0, S_REC, 0, 4'h0, 2'd1, 0);
    end
    applyStimulus("recover_fault", 0, 0, 4'b0001, 1, 0, S_FLT, 0, 4'b0001, 2'd0, 0);
    applyStimulus("clr_accept_c", 0, 0, 4'h0, 1, 1, S_REC, 0, 4'h0, 2'd0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("holdoff_c%0d", i), 0, 0, 4'h0, 1, 0,
                    (i < 9) ? S_REC : S_IDLE, 0, 4'h0, 2'd0, 0);
    end
    applyStimulus("run_via_idle", 0, 0, 4'h0, 1, 0, S_RUN, 1, 4'h0, 2'd0, 0);

    applyStimulus("fault_ch1", 0, 0, 4'b0010, 1, 0, S_FLT, 0, 4'b0010, 2'd1, 0);
    applyStimulus("clr_accept_d", 0, 0, 4'h0, 0, 1, S_REC, 0, 4'h0, 2'd1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("holdoff_d%0d", i), 0, 0, 4'h0, 0, 0, S_REC, 0, 4'h0, 2'd1, 0);
    end
    applyStimulus("reset_mid_recover", 0, 1, 4'h0, 0, 0, S_IDLE, 0, 4'h0, 2'd0, 0);
    applyStimulus("post_reset_idle", 0, 0, 4'h0, 0, 0, S_IDLE, 0, 4'h0, 2'd0, 0);
    applyStimulus("idle_to_fault", 0, 0, 4'b1000, 0, 0, S_FLT, 0, 4'b1000, 2'd3, 0);
    applyStimulus("clr_rejected_b", 0, 0, 4'b1000, 0, 1, S_FLT, 0, 4'b1000, 2'd3, 1);
    applyStimulus("clr_accept_e", 0, 0, 4'h0, 0, 1, S_REC, 0, 4'h0, 2'd3, 0);

    applyStimulus("m_reset", 1, 1, 4'h0, 0, 0, S_IDLE, 0, 4'h0, 2'd0, 0);
    applyStimulus("m_run_start", 1, 0, 4'h0, 1, 0, S_RUN, 1, 4'h0, 2'd0, 0);
    applyStimulus("m_masked_ch0", 1, 0, 4'b0001, 1, 0, S_RUN, 1, 4'h0, 2'd0, 0);
    applyStimulus("m_masked_ch0_b", 1, 0, 4'b0001, 1, 0, S_RUN, 1, 4'h0, 2'd0, 0);
    applyStimulus("m_fault_ch1", 1, 0, 4'b0011, 1, 0, S_FLT, 0, 4'b0010, 2'd1, 0);
    applyStimulus("m_clr_accept", 1, 0, 4'b0001, 1, 1, S_REC, 0, 4'h0, 2'd1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("m_holdoff%0d", i), 1, 0, 4'h0, 1, 0, S_REC, 0, 4'h0, 2'd1, 0);
    end
    applyStimulus("m_reset_mid_recover", 1, 1, 4'h0, 1, 0, S_IDLE, 0, 4'h0, 2'd0, 0);
    applyStimulus("m_post_reset", 1, 0, 4'h0, 0, 0, S_IDLE, 0, 4'h0, 2'd0, 0);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
